// File: rtl/sram_frame_arbiter_if.sv
// Signal bundle between the SRAM frame arbiter, its display/pixel-writer clients and the SRAM pads.
// The master modport is the environment side; the slave modport is the arbiter.
interface sram_frame_arbiter_if;
  logic        iRdReq;
  logic [16:0] iRdAddr;
  logic        oRdAck;
  logic [23:0] oRdData;
  logic        oRdValid;
  logic        iWrReq;
  logic [16:0] iWrAddr;
  logic [23:0] iWrData;
  logic        oWrReady;
  logic        iWrFrameDone;
  logic        iDispFrameStart;
  logic        oDispPage;
  logic        oSwapPending;
  logic [17:0] oSRAMAddrPort;
  logic [23:0] oSRAMDataOut;
  logic        oSRAMDataOE;
  logic [23:0] iSRAMDataIn;
  logic        oSRAMWriteEnablePort;
  logic        oSRAMOutputEnablePort;

  modport master (
    output iRdReq, iRdAddr, iWrReq, iWrAddr, iWrData, iWrFrameDone, iDispFrameStart, iSRAMDataIn,
    input  oRdAck, oRdData, oRdValid, oWrReady, oDispPage, oSwapPending, oSRAMAddrPort,
           oSRAMDataOut, oSRAMDataOE, oSRAMWriteEnablePort, oSRAMOutputEnablePort
  );

  modport slave (
    input  iRdReq, iRdAddr, iWrReq, iWrAddr, iWrData, iWrFrameDone, iDispFrameStart, iSRAMDataIn,
    output oRdAck, oRdData, oRdValid, oWrReady, oDispPage, oSwapPending, oSRAMAddrPort,
           oSRAMDataOut, oSRAMDataOE, oSRAMWriteEnablePort, oSRAMOutputEnablePort
  );
endinterface

// File: rtl/sram_frame_arbiter.sv
// Single-SRAM arbiter: read-priority scan-out, FIFO-buffered pixel writes with anti-starvation,
// and double-buffered page swapping at display frame boundaries.
module sram_frame_arbiter #(
  parameter int WFIFO_DEPTH   = 4,
  parameter int MAX_RD_STREAK = 8
) (
  input  logic                 iCLOCKA,
  input  logic                 iRESET,
  sram_frame_arbiter_if.slave  bus
);
  localparam int PW = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
  localparam int CW = $clog2(WFIFO_DEPTH + 1);
  localparam int SW = $clog2(MAX_RD_STREAK + 1);
  localparam int EW = 1 + 17 + 24;

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, WR3} state_t;

  state_t        state_q;
  logic [EW-1:0] fifo_q [WFIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q;
  logic          page_q, page_d, pend_q, pend_d;
  logic [17:0]   addr_q;
  logic [23:0]   dout_q, rd_data_q;
  logic          doe_q, we_n_q, oe_n_q, rd_ack_q, rd_valid_q;

  logic          fifo_full, fifo_empty, push, pop, grant_wr, grant_rd;
  logic [EW-1:0] head;

  assign fifo_full  = (cnt_q == CW'(WFIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign push       = bus.iWrReq && !fifo_full;
  assign pop        = (state_q == WR3);
  assign head       = fifo_q[rptr_q];
  assign grant_wr   = (state_q == IDLE) && !fifo_empty &&
                      (!bus.iRdReq || (streak_q == SW'(MAX_RD_STREAK)));
  assign grant_rd   = (state_q == IDLE) && !grant_wr && bus.iRdReq;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    page_d = page_q;
    pend_d = pend_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // A frame-done arriving with nothing pending only arms the swap; it never swaps in the same cycle.
    if (pend_q && bus.iDispFrameStart) begin
      page_d = ~page_q;
      pend_d = 1'b0;
    end
    if (bus.iWrFrameDone) pend_d = 1'b1;
  end

  // Entries are tagged with the back page at push time and keep that tag across swaps.
  always_ff @(posedge iCLOCKA) begin
    if (push) fifo_q[wptr_q] <= {~page_q, bus.iWrAddr, bus.iWrData};
  end

  always_ff @(posedge iCLOCKA) begin
    if (!iRESET) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      streak_q   <= '0;
      page_q     <= 1'b0;
      pend_q     <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      rd_data_q  <= '0;
      doe_q      <= 1'b0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      rd_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      page_q     <= page_d;
      pend_q     <= pend_d;
      rd_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      if (fifo_empty || grant_wr)
        streak_q <= '0;
      else if (grant_rd && (streak_q != SW'(MAX_RD_STREAK)))
        streak_q <= streak_q + SW'(1);
      unique case (state_q)
        IDLE: begin
          if (grant_wr) begin
            state_q <= WR1;
            addr_q  <= head[EW-1 -: 18];
            dout_q  <= head[23:0];
            doe_q   <= 1'b1;
            oe_n_q  <= 1'b1;
          end else if (grant_rd) begin
            state_q  <= RD1;
            addr_q   <= {page_q, bus.iRdAddr};
            oe_n_q   <= 1'b0;
            rd_ack_q <= 1'b1;
          end
        end
        RD1: state_q <= RD2;
        RD2: begin
          rd_data_q  <= bus.iSRAMDataIn;
          rd_valid_q <= 1'b1;
          oe_n_q     <= 1'b1;
          state_q    <= IDLE;
        end
        WR1: begin
          we_n_q  <= 1'b0;
          state_q <= WR2;
        end
        WR2: begin
          we_n_q  <= 1'b1;
          state_q <= WR3;
        end
        WR3: begin
          doe_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oRdAck                = rd_ack_q;
  assign bus.oRdData               = rd_data_q;
  assign bus.oRdValid              = rd_valid_q;
  assign bus.oWrReady              = !fifo_full;
  assign bus.oDispPage             = page_q;
  assign bus.oSwapPending          = pend_q;
  assign bus.oSRAMAddrPort         = addr_q;
  assign bus.oSRAMDataOut          = dout_q;
  assign bus.oSRAMDataOE           = doe_q;
  assign bus.oSRAMWriteEnablePort  = we_n_q;
  assign bus.oSRAMOutputEnablePort = oe_n_q;
endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Scoreboard bench for sram_frame_arbiter: stimulus queues expected SRAM cycles, a monitor pops them.
module tb_sram_frame_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_frame_arbiter_if bus ();
  sram_frame_arbiter #(.WFIFO_DEPTH(4), .MAX_RD_STREAK(8)) dut (
    .iCLOCKA(clk), .iRESET(rst_n), .bus(bus)
  );

  function automatic logic [23:0] pad_model(input logic [17:0] a);
    return {a[5:0], a} ^ 24'h5A5A5A;
  endfunction
  assign bus.iSRAMDataIn = pad_model(bus.oSRAMAddrPort);

  typedef struct packed { logic is_wr; logic [17:0] addr; logic [23:0] data; } ev_t;
  typedef struct packed { int due; logic [23:0] data; } rd_t;
  ev_t exp_q[$];
  rd_t rdq[$];
  int  ack_cyc[$];
  int  n_chk = 0, n_pass = 0;
  int  viol = 0, we_low_cnt = 0, doe_cnt = 0, oe_low_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic fail_evt(input string name, input logic [63:0] act);
    n_chk++;
    $display("FAIL %s: got 0x%0h, required no such event", name, act);
  endtask

  task automatic exp_rd(input logic [17:0] a);
    exp_q.push_back('{is_wr: 1'b0, addr: a, data: 24'h0});
  endtask

  task automatic exp_wr(input logic [17:0] a, input logic [23:0] d);
    exp_q.push_back('{is_wr: 1'b1, addr: a, data: d});
  endtask

  // Monitor: compares every SRAM access and read return against the scoreboard.
  ev_t mon_e;
  rd_t mon_r;
  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.oSRAMWriteEnablePort && !bus.oSRAMOutputEnablePort) viol++;
      if (bus.oSRAMDataOE && !bus.oSRAMOutputEnablePort) viol++;
      if (!bus.oSRAMWriteEnablePort) we_low_cnt++;
      if (bus.oSRAMDataOE) doe_cnt++;
      if (!bus.oSRAMOutputEnablePort) oe_low_cnt++;
      if (bus.oRdAck) begin
        ack_cyc.push_back(cyc);
        if (exp_q.size() == 0) fail_evt("rd_ack_unexpected", bus.oSRAMAddrPort);
        else begin
          mon_e = exp_q.pop_front();
          if (mon_e.is_wr) fail_evt("rd_ack_while_write_expected", bus.oSRAMAddrPort);
          else check("rd_addr", bus.oSRAMAddrPort, mon_e.addr);
          rdq.push_back('{due: cyc + 2, data: pad_model(mon_e.addr)});
        end
      end
      if (bus.oRdValid) begin
        if (rdq.size() == 0) fail_evt("rd_valid_unexpected", bus.oRdData);
        else begin
          mon_r = rdq.pop_front();
          check("rd_data", bus.oRdData, mon_r.data);
          check("rd_latency", cyc, mon_r.due);
        end
      end
      if (!bus.oSRAMWriteEnablePort) begin
        if (exp_q.size() == 0) fail_evt("wr_unexpected", bus.oSRAMAddrPort);
        else begin
          mon_e = exp_q.pop_front();
          if (!mon_e.is_wr) fail_evt("wr_while_read_expected", bus.oSRAMAddrPort);
          else begin
            check("wr_addr", bus.oSRAMAddrPort, mon_e.addr);
            check("wr_data", bus.oSRAMDataOut, mon_e.data);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || rdq.size() != 0) && n < 2000) begin
      step();
      if (exp_q.size() == 0) bus.iRdReq = 1'b0;
      n++;
    end
    if (n >= 2000) begin
      fail_evt({name, "_timeout"}, exp_q.size());
      exp_q.delete();
      rdq.delete();
    end
    bus.iRdReq = 1'b0;
  endtask

  task automatic wait_q(input int target, input string name);
    int n = 0;
    while (exp_q.size() > target && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) fail_evt({name, "_wait_timeout"}, exp_q.size());
  endtask

  task automatic push_wr(input logic [16:0] a, input logic [23:0] d);
    bus.iWrReq  = 1'b1;
    bus.iWrAddr = a;
    bus.iWrData = d;
    step();
    bus.iWrReq  = 1'b0;
  endtask

  task automatic pulse(input bit done, input bit start);
    bus.iWrFrameDone    = done;
    bus.iDispFrameStart = start;
    step();
    bus.iWrFrameDone    = 1'b0;
    bus.iDispFrameStart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, doe0, oe0;
    rst_n = 1'b0;
    bus.iRdReq = 0; bus.iRdAddr = '0; bus.iWrReq = 0; bus.iWrAddr = '0; bus.iWrData = '0;
    bus.iWrFrameDone = 0; bus.iDispFrameStart = 0;
    repeat (3) step();
    check("rst_we",    bus.oSRAMWriteEnablePort, 1);
    check("rst_oe",    bus.oSRAMOutputEnablePort, 1);
    check("rst_doe",   bus.oSRAMDataOE, 0);
    check("rst_addr",  bus.oSRAMAddrPort, 0);
    check("rst_dout",  bus.oSRAMDataOut, 0);
    check("rst_ack",   bus.oRdAck, 0);
    check("rst_valid", bus.oRdValid, 0);
    check("rst_rdata", bus.oRdData, 0);
    check("rst_page",  bus.oDispPage, 0);
    check("rst_pend",  bus.oSwapPending, 0);
    check("rst_ready", bus.oWrReady, 1);
    rst_n = 1'b1;
    step();

    // Read-only stream from page 0.
    ack_cyc.delete();
    repeat (4) exp_rd(18'h00005);
    bus.iRdAddr = 17'h00005;
    bus.iRdReq  = 1'b1;
    drain("read_only");
    check("ack_count", ack_cyc.size(), 4);
    for (int i = 1; i < 4 && i < ack_cyc.size(); i++)
      check("ack_spacing", ack_cyc[i] - ack_cyc[i-1], 3);

    // Single write with no competing reads.
    we0 = we_low_cnt; doe0 = doe_cnt; oe0 = oe_low_cnt;
    exp_wr(18'h3ABCD, 24'h00F0F0);
    push_wr(17'h1ABCD, 24'h00F0F0);
    drain("single_write");
    repeat (4) step();
    check("we_low_cycles", we_low_cnt - we0, 1);
    check("doe_cycles",    doe_cnt - doe0, 3);
    check("oe_low_cycles", oe_low_cnt - oe0, 0);

    // Starvation guard: one write behind a continuous read stream.
    exp_rd(18'h00007);
    repeat (8) exp_rd(18'h00007);
    exp_wr(18'h20010, 24'h123456);
    repeat (2) exp_rd(18'h00007);
    bus.iRdAddr = 17'h00007;
    bus.iRdReq  = 1'b1;
    wait_q(11, "starve");
    push_wr(17'h00010, 24'h123456);
    drain("starve");

    // FIFO full: five pushes while reads hog the bus; the fifth is refused.
    exp_rd(18'h00003);
    for (int i = 0; i < 4; i++) begin
      repeat (8) exp_rd(18'h00003);
      exp_wr(18'h20100 + 18'(i), 24'hA00000 + 24'(i));
    end
    bus.iRdAddr = 17'h00003;
    bus.iRdReq  = 1'b1;
    wait_q(36, "full");
    for (int i = 0; i < 5; i++) begin
      check("ready_before_push", bus.oWrReady, (i < 4) ? 1 : 0);
      bus.iWrReq  = 1'b1;
      bus.iWrAddr = 17'h00100 + 17'(i);
      bus.iWrData = 24'hA00000 + 24'(i);
      step();
    end
    bus.iWrReq = 1'b0;
    drain("full");
    repeat (12) step();
    check("ready_after_full", bus.oWrReady, 1);

    // Page swap at the frame boundary.
    pulse(1'b1, 1'b0);
    check("swap_pend_set", bus.oSwapPending, 1);
    check("page_before_swap", bus.oDispPage, 0);
    repeat (10) step();
    pulse(1'b0, 1'b1);
    check("page_after_swap", bus.oDispPage, 1);
    check("pend_after_swap", bus.oSwapPending, 0);
    exp_rd(18'h20009);
    bus.iRdAddr = 17'h00009;
    bus.iRdReq  = 1'b1;
    drain("swap_read");
    exp_wr(18'h00020, 24'h55AA55);
    push_wr(17'h00020, 24'h55AA55);
    drain("swap_write");
    repeat (4) step();
    pulse(1'b0, 1'b1);
    check("page_start_no_pend", bus.oDispPage, 1);
    check("pend_start_no_pend", bus.oSwapPending, 0);
    pulse(1'b1, 1'b1);
    check("page_both_pulses", bus.oDispPage, 1);
    check("pend_both_pulses", bus.oSwapPending, 1);
    pulse(1'b0, 1'b1);
    check("page_swap_back", bus.oDispPage, 0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    check("page_swap_again", bus.oDispPage, 1);

    // Reset while WE is low: access aborts and the FIFO is flushed.
    exp_wr(18'h00030, 24'h111111);
    push_wr(17'h00030, 24'h111111);
    push_wr(17'h00031, 24'h222222);
    begin
      int n = 0;
      while (bus.oSRAMWriteEnablePort && n < 50) begin
        step();
        n++;
      end
      if (n >= 50) fail_evt("wr2_wait_timeout", n);
    end
    rst_n = 1'b0;
    step();
    check("rst_mid_we",    bus.oSRAMWriteEnablePort, 1);
    check("rst_mid_doe",   bus.oSRAMDataOE, 0);
    check("rst_mid_ready", bus.oWrReady, 1);
    check("rst_mid_page",  bus.oDispPage, 0);
    check("rst_mid_pend",  bus.oSwapPending, 0);
    step();
    rst_n = 1'b1;
    we0 = we_low_cnt;
    repeat (20) step();
    check("no_write_after_reset", we_low_cnt - we0, 0);
    check("ready_after_reset", bus.oWrReady, 1);

    check("bus_rule_violations", viol, 0);
    check("scoreboard_empty", exp_q.size() + rdq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
